// File: rtl/aes_shiftrows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows stage (Nb = 4, 6, 8).
// Valid/ready handshake, collapsing bubbles, wrapping output block counter.
module aes_shiftrows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    blk_cnt
);

    localparam int DATA_W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("aes_shiftrows_pipe: STAGES must be 1..4");
        end
    endgenerate

    // Rijndael row offsets: wide blocks skip offset 2
    function automatic int row_off(input int r);
        if (NB == 8) begin
            case (r)
                0:       return 0;
                1:       return 1;
                2:       return 3;
                default: return 4;
            endcase
        end
        return r;
    endfunction

    logic [DATA_W-1:0]              perm;
    logic [STAGES-1:0]              vld;
    logic [STAGES-1:0][DATA_W-1:0]  dat;
    logic [STAGES:0]                rdy;

    always_comb begin
        perm = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                int src;
                if (in_inv)
                    src = (c - row_off(r) + NB) % NB;
                else
                    src = (c + row_off(r)) % NB;
                perm[DATA_W-1-8*(4*c+r) -: 8] =
                    in_data[DATA_W-1-8*(4*src+r) -: 8];
            end
        end
    end

    // A stage may load when empty or when its content leaves this cycle
    always_comb begin
        rdy = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~vld[i] | rdy[i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            dat <= '0;
        end else begin
            if (rdy[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= perm;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        dat[i] <= dat[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (cnt_clr) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];

endmodule
